// File: rtl/jtopll_pkg.sv
// Shared definitions for the OPLL host write sequencer: FSM encoding and
// the default post-address / post-data wait times of the OPLL core.
package jtopll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AWR  = 3'd1,
    ST_AWT  = 3'd2,
    ST_DWR  = 3'd3,
    ST_DWT  = 3'd4
  } wr_state_e;

  localparam int OPLL_ADDR_WAIT = 12;
  localparam int OPLL_DATA_WAIT = 84;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jtopll_wrfifo.sv
// DEPTH x W synchronous FIFO with first-word-fall-through read data.
// Pointers wrap modulo DEPTH; full/empty are derived from the occupancy count.
module jtopll_wrfifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // NOTE: every signal gets its default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only read behind a
  // valid level, so clearing them would add reset fan-out for no benefit.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jtopll_wrseq.sv
// Host-side write sequencer for the OPLL core: queues {reg,data} writes and
// replays them as timed address/data bus cycles. Optional JTOPLL_WRSEQ_SKIPADDR_EN
// skips the address cycle when the register index repeats.
module jtopll_wrseq
  import jtopll_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int ADDR_WAIT = OPLL_ADDR_WAIT,
  parameter int DATA_WAIT = OPLL_DATA_WAIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_reg,
  input  logic [7:0]  req_data,
  output logic [7:0]  opl_din,
  output logic        opl_addr,
  output logic        opl_cs_n,
  output logic        opl_wr_n,
  output logic        busy,
  output logic [AW:0] level
);

  localparam int CW = $clog2(max_int(ADDR_WAIT, DATA_WAIT)) + 1;

  wr_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    hold_data_q, hold_data_d;
  logic [7:0]    din_q, din_d;
  logic          addr_q, addr_d;
  logic          cs_n_q, cs_n_d;
  logic          wr_n_q, wr_n_d;
  logic          fifo_pop, fifo_full, fifo_empty, skip_addr;
  logic [15:0]   fifo_dout;

`ifdef JTOPLL_WRSEQ_SKIPADDR_EN
  logic [7:0] last_reg_q, last_reg_d;
  logic       last_vld_q, last_vld_d;
`endif

  jtopll_wrfifo #(.DEPTH(DEPTH), .AW(AW), .W(16)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .din   ({req_reg, req_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_ready = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign opl_din   = din_q;
  assign opl_addr  = addr_q;
  assign opl_cs_n  = cs_n_q;
  assign opl_wr_n  = wr_n_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    din_d       = din_q;
    addr_d      = addr_q;
    cs_n_d      = cs_n_q;
    wr_n_d      = wr_n_q;
    fifo_pop    = 1'b0;
    skip_addr   = 1'b0;
`ifdef JTOPLL_WRSEQ_SKIPADDR_EN
    last_reg_d  = last_reg_q;
    last_vld_d  = last_vld_q;
    skip_addr   = last_vld_q && (fifo_dout[15:8] == last_reg_q);
`endif
    if (cen) begin
      // Strobes last exactly one cen cycle; only strobe entries pull them low.
      cs_n_d = 1'b1;
      wr_n_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            hold_data_d = fifo_dout[7:0];
            cs_n_d      = 1'b0;
            wr_n_d      = 1'b0;
            if (skip_addr) begin
              state_d = ST_DWR;
              addr_d  = 1'b1;
              din_d   = fifo_dout[7:0];
            end else begin
              state_d = ST_AWR;
              addr_d  = 1'b0;
              din_d   = fifo_dout[15:8];
`ifdef JTOPLL_WRSEQ_SKIPADDR_EN
              last_reg_d = fifo_dout[15:8];
              last_vld_d = 1'b1;
`endif
            end
          end
        end
        ST_AWR: begin
          state_d = ST_AWT;
          cnt_d   = CW'(ADDR_WAIT - 1);
        end
        ST_AWT: begin
          if (cnt_q == '0) begin
            state_d = ST_DWR;
            cs_n_d  = 1'b0;
            wr_n_d  = 1'b0;
            addr_d  = 1'b1;
            din_d   = hold_data_q;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_DWR: begin
          state_d = ST_DWT;
          cnt_d   = CW'(DATA_WAIT - 1);
        end
        ST_DWT: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_data_q <= '0;
      din_q       <= '0;
      addr_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      din_q       <= din_d;
      addr_q      <= addr_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

`ifdef JTOPLL_WRSEQ_SKIPADDR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg_q <= 8'hFF;
      last_vld_q <= 1'b0;
    end else begin
      last_reg_q <= last_reg_d;
      last_vld_q <= last_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_jtopll_wrseq.sv
// Scoreboard bench for jtopll_wrseq: stimulus pushes expected bus strobes into
// a queue, a negedge monitor pops and compares each strobe the DUT presents.
module tb_jtopll_wrseq;

  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_reg = '0;
  logic [7:0]  req_data = '0;
  logic [7:0]  opl_din;
  logic        opl_addr, opl_cs_n, opl_wr_n, busy;
  logic [AW:0] level;

  jtopll_wrseq #(.DEPTH(8), .AW(AW), .ADDR_WAIT(12), .DATA_WAIT(84)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .opl_din   (opl_din),
    .opl_addr  (opl_addr),
    .opl_cs_n  (opl_cs_n),
    .opl_wr_n  (opl_wr_n),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  // cen pattern: 0 = off, N = one cen every N clocks
  int cen_div = 0;
  int div_cnt = 0;
  int cen_cnt = 0;
  always @(posedge clk) div_cnt <= (cen_div <= 1 || div_cnt >= cen_div - 1) ? 0 : div_cnt + 1;
  assign cen = (cen_div != 0) && (div_cnt == 0);
  always @(posedge clk) if (cen) cen_cnt <= cen_cnt + 1;

  typedef struct packed {
    logic       addr;
    logic [7:0] din;
  } strobe_s;

  strobe_s exp_q[$];
  int      strobe_times[$];
  int      busy_fall_t = 0;
  int      low_clks = 0;
  bit      chk_low = 1'b0;
  int      last_push_cnt = 0;
  int      n_pass = 0;
  int      n_checks = 0;
  bit         m_last_vld = 1'b0;
  logic [7:0] m_last_reg = 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  function automatic void model_write(input logic [7:0] r, input logic [7:0] d);
`ifdef JTOPLL_WRSEQ_SKIPADDR_EN
    if (!(m_last_vld && r == m_last_reg)) begin
      exp_q.push_back('{addr: 1'b0, din: r});
      m_last_reg = r;
      m_last_vld = 1'b1;
    end
`else
    exp_q.push_back('{addr: 1'b0, din: r});
`endif
    exp_q.push_back('{addr: 1'b1, din: d});
  endfunction

  // Monitor: compares every falling cs_n against the scoreboard head
  logic prev_cs_n = 1'b1;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (prev_cs_n && !opl_cs_n) begin
      strobe_times.push_back(cen_cnt);
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        strobe_s e;
        e = exp_q.pop_front();
        check("strobe_addr", opl_addr, e.addr);
        check("strobe_din", opl_din, e.din);
        check("strobe_wr_n", opl_wr_n, 0);
      end
    end
    if (!opl_cs_n) low_clks++;
    else if (!prev_cs_n) begin
      if (chk_low) check("strobe_low_clks", low_clks, cen_div);
      low_clks = 0;
    end
    if (prev_busy && !busy) busy_fall_t = cen_cnt;
    prev_cs_n = opl_cs_n;
    prev_busy = busy;
  end

  task automatic push(input logic [7:0] r, input logic [7:0] d, input bit model);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_reg   = r;
    req_data  = d;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    last_push_cnt = cen_cnt;
    check("push_accepted", n < 2000, 1);
    if (model && n < 2000) model_write(r, d);
  endtask

  task automatic wait_idle(input int max_clk, input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < max_clk) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, (!busy && exp_q.size() == 0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_t6;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", opl_cs_n, 1);
    check("rst_wr_n", opl_wr_n, 1);
    check("rst_din", opl_din, 0);
    check("rst_addr", opl_addr, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    rst_n = 1'b1;

    // T1: single write, cen every clock
    cen_div = 1;
    base = strobe_times.size();
    push(8'h10, 8'h55, 1'b1);
    check("t1_busy_after_push", busy, 1);
    wait_idle(300, "t1_idle");
    check("t1_strobe_count", strobe_times.size() - base, 2);
    if (strobe_times.size() >= base + 2) begin
      check("t1_latency", strobe_times[base] - last_push_cnt, 1);
      check("t1_addr_to_data", strobe_times[base+1] - strobe_times[base], 13);
      check("t1_data_to_idle", busy_fall_t - strobe_times[base+1], 85);
    end

    // T2: cen every 4th clock, two back-to-back writes
    cen_div = 4;
    chk_low = 1'b1;
    base = strobe_times.size();
    push(8'h31, 8'hA1, 1'b1);
    push(8'h32, 8'hA2, 1'b1);
    wait_idle(2000, "t2_idle");
    chk_low = 1'b0;
    check("t2_strobe_count", strobe_times.size() - base, 4);
    if (strobe_times.size() >= base + 4) begin
      check("t2_a1_d1", strobe_times[base+1] - strobe_times[base], 13);
      check("t2_d1_a2", strobe_times[base+2] - strobe_times[base+1], 86);
      check("t2_a2_d2", strobe_times[base+3] - strobe_times[base+2], 13);
    end

    // T3: fill while stalled, 9th write refused, then drain in order
    cen_div = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), 8'h80 + 8'(i), 1'b1);
    check("t3_level_full", level, 8);
    check("t3_ready_full", req_ready, 0);
    check("t3_busy_stalled", busy, 1);
    @(negedge clk);
    req_valid = 1'b1;
    req_reg   = 8'h48;
    req_data  = 8'h88;
    repeat (3) @(negedge clk);
    check("t3_ninth_held_level", level, 8);
    check("t3_ninth_held_ready", req_ready, 0);
    req_valid = 1'b0;
    base = strobe_times.size();
    cen_div = 1;
    wait_idle(1500, "t3_idle");
    check("t3_strobe_count", strobe_times.size() - base, 16);

    // T5: push while full with a simultaneous pop
    cen_div = 0;
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i), 8'hC0 + 8'(i), 1'b1);
    check("t5_level_full", level, 8);
    @(negedge clk);
    req_valid = 1'b1;
    req_reg   = 8'h58;
    req_data  = 8'hC8;
    cen_div   = 1;
    @(posedge clk);
    #1;
    cen_div = 0;
    check("t5_refused_level", level, 7);
    check("t5_ready_after_pop", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("t5_accepted_level", level, 8);
    model_write(8'h58, 8'hC8);
    base = strobe_times.size();
    cen_div = 1;
    wait_idle(1500, "t5_idle");
    check("t5_strobe_count", strobe_times.size() - base + 1, 18);

    // T4: reset during AWT of the 2nd of three queued writes
    base = strobe_times.size();
    exp_q.push_back('{addr: 1'b0, din: 8'h61});
    exp_q.push_back('{addr: 1'b1, din: 8'h11});
    exp_q.push_back('{addr: 1'b0, din: 8'h62});
    push(8'h61, 8'h11, 1'b0);
    push(8'h62, 8'h22, 1'b0);
    push(8'h63, 8'h33, 1'b0);
    begin
      int n = 0;
      while (strobe_times.size() < base + 3 && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("t4_reached_second_addr", strobe_times.size() - base, 3);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_cs_n", opl_cs_n, 1);
    check("t4_rst_wr_n", opl_wr_n, 1);
    check("t4_rst_level", level, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_ready", req_ready, 1);
    m_last_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_no_more_strobes", strobe_times.size() - base, 3);
    check("t4_scoreboard_empty", exp_q.size(), 0);

    // T6: repeated register index (address skip when enabled)
    base = strobe_times.size();
    push(8'h20, 8'h01, 1'b1);
    push(8'h20, 8'h02, 1'b1);
    push(8'h21, 8'h03, 1'b1);
    wait_idle(1000, "t6_idle");
`ifdef JTOPLL_WRSEQ_SKIPADDR_EN
    exp_t6 = 5;
`else
    exp_t6 = 6;
`endif
    check("t6_strobe_count", strobe_times.size() - base, exp_t6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
